// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame constants and baud divider helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic multi-flop synchronizer for asynchronous single-bit inputs.
module sync2
  import uart_pkg::*;
#(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {SYNC_STAGES{INIT}};
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a 1-deep valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int IW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  if (DIV < 4) begin : g_div_chk
    $error("uart_rx: CLK_HZ/BAUD must be >= 4");
  end

  logic                 rx_s;
  uart_state_e          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        bit_idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 brk, brk_n;
  logic                 done_q, done_n, ferr_n;

  sync2 #(.INIT(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = bit_idx;
    shift_n = shift;
    brk_n   = brk;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        // after a framing error the line must return high before re-arming
        if (brk) begin
          if (rx_s) brk_n = 1'b0;
        end else if (!rx_s) begin
          cnt_n   = HALF_M1;
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rx_s) state_n = IDLE;
          else begin
            cnt_n   = FULL_M1;
            idx_n   = '0;
            state_n = DATA;
          end
        end else cnt_n = cnt - 1'b1;
      end
      DATA: begin
        if (cnt == '0) begin
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          cnt_n   = FULL_M1;
          if (bit_idx == LAST_IDX) state_n = STOP;
          else                     idx_n   = bit_idx + 1'b1;
        end else cnt_n = cnt - 1'b1;
      end
      STOP: begin
        // leave at mid-stop so a start bit right after it is not missed
        if (cnt == '0) begin
          state_n = IDLE;
          if (rx_s) done_n = 1'b1;
          else begin
            ferr_n = 1'b1;
            brk_n  = 1'b1;
          end
        end else cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      brk       <= 1'b0;
      done_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= idx_n;
      shift     <= shift_n;
      brk       <= brk_n;
      done_q    <= done_n;
      frame_err <= ferr_n;
    end
  end

  // holding register: a completed byte replaces the old one only if it is being drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_q) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else overrun <= 1'b1;
      end else if (valid && ready) valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=12: vector table, directed corner cases, random frames with drift.
module tb_uart_rx;

  localparam int DIV = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  uart_rx #(.CLK_HZ(12000000), .BAUD(1000000)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // consumer: fixed level or random per cycle
  logic ready_fix = 1'b0, rand_ready = 1'b0;
  initial forever begin
    @(negedge clk);
    ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // monitor: log accepted bytes, pulses, and holding-register stability
  logic [7:0] acc_q[$];
  int ferr_cnt = 0, ovr_cnt = 0, vhigh_cnt = 0, stab_err = 0, rise_cyc = 0;
  logic pv = 1'b0, pacc = 1'b0;
  logic [7:0] pd = 8'h00;
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (valid && ready) acc_q.push_back(data);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (valid) vhigh_cnt++;
      if (valid && !pv) rise_cyc = cyc;
      if (pv && !pacc && (!valid || data != pd)) stab_err++;
    end
    pv = valid; pd = data; pacc = valid && ready;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // line driver: bit k ends at round((k+1)*period), period = DIV*(1+drift)
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real drift);
    real per;
    logic [9:0] fr;
    int t;
    per = DIV * (1.0 + drift);
    fr  = {stop_bit, b, 1'b0};
    t   = 0;
    for (int k = 0; k < 10; k++) begin
      int end_t;
      end_t = $rtoi((k + 1) * per + 0.5);
      rx = fr[k];
      while (t < end_t) begin
        @(negedge clk);
        t++;
      end
    end
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         n_ok;
    int         n_ferr;
  } vec_t;

  vec_t vecs[8];
  int   b_acc, b_fe, b_ov, b_vh, b_st, t0;
  logic [7:0] exp_q[$];
  bit   ok;

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 1, 0};
    vecs[2] = '{8'h55, 1'b1, 1, 0};
    vecs[3] = '{8'hAA, 1'b1, 1, 0};
    vecs[4] = '{8'h3C, 1'b0, 0, 1};
    vecs[5] = '{8'h80, 1'b1, 1, 0};
    vecs[6] = '{8'h01, 1'b1, 1, 0};
    vecs[7] = '{8'h7E, 1'b1, 1, 0};

    // reset state
    idle(3);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    idle(5);

    // single byte 0x55: latency and one-cycle valid
    ready_fix = 1'b1;
    idle(3);
    b_acc = acc_q.size(); b_fe = ferr_cnt; b_ov = ovr_cnt; b_vh = vhigh_cnt;
    t0 = cyc + 1;
    send_frame(8'h55, 1'b1, 0.0);
    idle(20);
    chk("single_latency", rise_cyc - t0, 117);
    chk("single_vhigh", vhigh_cnt - b_vh, 1);
    chk("single_count", acc_q.size() - b_acc, 1);
    if (acc_q.size() > b_acc) chk("single_data", acc_q[b_acc], 8'h55);
    chk("single_ferr", ferr_cnt - b_fe, 0);
    chk("single_ovr", ovr_cnt - b_ov, 0);

    // table of single frames, ready held high
    foreach (vecs[i]) begin
      b_acc = acc_q.size(); b_fe = ferr_cnt;
      send_frame(vecs[i].b, vecs[i].stop, 0.0);
      idle(30);
      chk($sformatf("vec%0d_count", i), acc_q.size() - b_acc, vecs[i].n_ok);
      chk($sformatf("vec%0d_ferr", i), ferr_cnt - b_fe, vecs[i].n_ferr);
      if (vecs[i].n_ok == 1 && acc_q.size() > b_acc)
        chk($sformatf("vec%0d_data", i), acc_q[b_acc], vecs[i].b);
    end

    // back-to-back with late handshake
    ready_fix = 1'b0;
    idle(3);
    b_acc = acc_q.size(); b_ov = ovr_cnt; b_st = stab_err;
    fork
      begin
        send_frame(8'hA3, 1'b1, 0.0);
        send_frame(8'h0F, 1'b1, 0.0);
      end
      begin
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
          @(negedge clk);
          if (valid) ok = 1'b1;
        end
        chk("b2b_wait_valid", ok, 1);
        idle(20);
        chk("b2b_held_valid", valid, 1);
        chk("b2b_held_data", data, 8'hA3);
        ready_fix = 1'b1;
      end
    join
    idle(30);
    chk("b2b_count", acc_q.size() - b_acc, 2);
    if (acc_q.size() >= b_acc + 2) begin
      chk("b2b_first", acc_q[b_acc], 8'hA3);
      chk("b2b_second", acc_q[b_acc+1], 8'h0F);
    end
    chk("b2b_ovr", ovr_cnt - b_ov, 0);
    chk("b2b_stable", stab_err - b_st, 0);

    // overrun: ready low throughout
    ready_fix = 1'b0;
    idle(3);
    b_acc = acc_q.size(); b_ov = ovr_cnt;
    send_frame(8'h11, 1'b1, 0.0);
    send_frame(8'h22, 1'b1, 0.0);
    idle(30);
    chk("ovr_pulses", ovr_cnt - b_ov, 1);
    chk("ovr_valid", valid, 1);
    chk("ovr_data", data, 8'h11);
    ready_fix = 1'b1;
    idle(5);
    chk("ovr_drain_count", acc_q.size() - b_acc, 1);
    if (acc_q.size() > b_acc) chk("ovr_drain_data", acc_q[b_acc], 8'h11);

    // framing error then recovery
    b_acc = acc_q.size(); b_fe = ferr_cnt; b_vh = vhigh_cnt;
    send_frame(8'h3C, 1'b0, 0.0);
    idle(12);
    chk("fe_pulses", ferr_cnt - b_fe, 1);
    chk("fe_no_valid", vhigh_cnt - b_vh, 0);
    send_frame(8'h7E, 1'b1, 0.0);
    idle(20);
    chk("fe_next_count", acc_q.size() - b_acc, 1);
    if (acc_q.size() > b_acc) chk("fe_next_data", acc_q[b_acc], 8'h7E);

    // glitch: 4-cycle low pulse while idle
    b_vh = vhigh_cnt; b_fe = ferr_cnt;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(4);
    chk("glitch_busy_pre", busy, 1);
    idle(1);
    chk("glitch_busy_post", busy, 0);
    idle(30);
    chk("glitch_no_valid", vhigh_cnt - b_vh, 0);
    chk("glitch_no_ferr", ferr_cnt - b_fe, 0);

    // reset during bit 4 of 0xFF
    b_acc = acc_q.size(); b_fe = ferr_cnt; b_ov = ovr_cnt;
    rx = 1'b0;
    idle(DIV);
    rx = 1'b1;
    idle(4 * DIV + DIV / 2);
    chk("rstmid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_valid", valid, 0);
    chk("rstmid_data", data, 0);
    chk("rstmid_ferr", frame_err, 0);
    chk("rstmid_ovr", overrun, 0);
    idle(3);
    rst_n = 1'b1;
    idle(80);
    send_frame(8'h81, 1'b1, 0.0);
    idle(30);
    chk("rstmid_count", acc_q.size() - b_acc, 1);
    if (acc_q.size() > b_acc) chk("rstmid_data_after", acc_q[b_acc], 8'h81);
    chk("rstmid_no_ferr", ferr_cnt - b_fe, 0);
    chk("rstmid_no_ovr", ovr_cnt - b_ov, 0);

    // random frames with +/-2% drift, random gaps and random consumer stalls
    rand_ready = 1'b1;
    exp_q.delete();
    b_acc = acc_q.size(); b_fe = ferr_cnt; b_ov = ovr_cnt; b_st = stab_err;
    t0 = 0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic       good;
      real        drift;
      int         gap;
      b     = 8'($urandom);
      good  = ($urandom_range(0, 99) >= 15);
      drift = (real'($urandom_range(0, 400)) - 200.0) / 10000.0;
      gap   = good ? $urandom_range(0, 20) : $urandom_range(12, 30);
      send_frame(b, good, drift);
      if (good) exp_q.push_back(b);
      else      t0++;
      idle(gap);
    end
    idle(300);
    chk("rand_count", acc_q.size() - b_acc, exp_q.size());
    foreach (exp_q[i])
      if (b_acc + i < acc_q.size()) chk($sformatf("rand_byte%0d", i), acc_q[b_acc+i], exp_q[i]);
    chk("rand_ferr", ferr_cnt - b_fe, t0);
    chk("rand_ovr", ovr_cnt - b_ov, 0);
    chk("rand_stable", stab_err - b_st, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver, 8N1, LSB first. Counterpart to the machine's existing uart_tx output.
- Samples the asynchronous rx pin, recovers bytes, and presents each byte to the CPU bus / peripheral logic through a 1-deep valid/ready holding register.
- Flags framing errors and overruns.
- Instantiated inside machine next to the transmitter; the top-level testbench drives rx from its own tx model.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DIV, CLK_HZ/BAUD (derived localparam, integer division), clocks per bit; must be >= 4 (elaboration-time check).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial input, asynchronous, idle high.
- data  out  8  received byte, stable while valid=1.
- valid  out  1  byte available in holding register.
- ready  in  1  consumer accepts byte when valid&ready on a clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: new byte completed while holding register still full.
- busy  out  1  high while state != IDLE.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: data=0, valid=0, frame_err=0, overrun=0, busy=0; synchronizer flops=1; state=IDLE; counters=0.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- Latency: 2 cycles from the rx pin to rx_s.
- Bit counter counts DIV cycles per bit. Bit index counts 0..7.
- IDLE: when rx_s=0, load the cycle counter with DIV/2-1 and go to START.
- START: count down to 0, then resample rx_s.
  - rx_s=1: glitch; return to IDLE with no output.
  - rx_s=0: reload the counter with DIV-1 and go to DATA with bit index 0.
- DATA: on counter 0, shift rx_s into shift[7] (right shift, LSB first) and reload DIV-1.
  - After the bit-7 sample, go to STOP.
- STOP: on counter 0, sample rx_s.
  - rx_s=1: byte complete. Go to IDLE the same cycle, so a start bit immediately after the mid-stop sample is accepted.
  - rx_s=0: pulse frame_err, discard the byte, go to IDLE.
  - After a framing error, IDLE waits for rx_s=1 before arming again, so a held-low break does not retrigger.
- Byte complete with valid=0, or with valid=1 and ready=1 that same cycle: on the next edge data<=shift and valid<=1.
- Byte complete with valid=1 and ready=0: pulse overrun, keep the old data, drop the new byte.
- valid&ready with no completion: valid<=0 next edge; data holds its value.
- Output timing: valid rises exactly 2 + DIV/2 + 9*DIV cycles after the first clk edge that sees rx=0 at the pin, +1 for the register stage.
  - DIV=12 gives 2+6+108+1 = 117 cycles.
- Reset mid-frame aborts immediately to IDLE; any partial byte is lost.
- Baud tolerance: the sample point sits at bit centre ± one clk of phase. Sender drift within ±2% must be received correctly for DIV>=12.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding: IDLE=0, START=1, DATA=2, STOP=3, 2 bits;
  - function for the DIV computation;
  - constants DATA_BITS=8 and SYNC_STAGES=2, reused by uart_tx.
- One natural sub-module: sync2, a generic 2-flop synchronizer with reset value parameter INIT=1, reused for other async inputs (buttons).
- Remaining logic (FSM, counters, shift register, holding register) stays in uart_rx. Expected size: about 150-200 lines.

Test Plan (all with CLK_HZ=12000000, BAUD=1000000, so DIV=12):
- Single byte: drive frame 0x55 with ready held 1. Expect valid high for exactly 1 cycle at cycle 117 after the start edge, data=0x55, frame_err=0, overrun=0.
- Back-to-back with handshake: send 0xA3 then 0x0F with no idle gap and ready=0 until after the first valid, then ready=1. Expect data=0xA3 held until accepted, then data=0x0F.
  - Also check no overrun when ready is asserted before the second byte completes.
- Overrun: send 0x11 then 0x22 with ready=0 throughout. Expect data=0x11, valid=1, one overrun pulse at completion of 0x22, data remains 0x11.
- Framing error: send 0x3C with the stop bit driven low for 1 bit time, then high. Expect one frame_err pulse, valid stays 0. A following frame 0x7E is received correctly.
- Glitch rejection: a 4-cycle low pulse on rx while idle. Expect busy returns 0 at the mid-start check, no valid, no frame_err.
- Reset mid-frame: assert rst_n=0 during bit 4 of 0xFF, release, then send 0x81. Expect all outputs 0 during reset, only 0x81 delivered afterwards, no error pulses.
